// File: rtl/menu_anim_sequencer.sv
// Start-menu sprite sequencer: maps the scan position to frame-RAM addresses, alternates
// between two menu frames, and blinks the menu after the start key before reporting done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | menu inactive; frame 0 selected, counters loaded, visible
// ANIMATE | frames alternate every HOLD_FRAMES video frames
// BLINK   | frame frozen; visibility toggles every BLINK_PERIOD frames
// DONE    | blink finished; menu_done high until menu_en drops
module menu_anim_sequencer #(
    parameter int          IMG_W        = 120,
    parameter int          IMG_H        = 100,
    parameter int          X0           = 200,
    parameter int          Y0           = 140,
    parameter int          HOLD_FRAMES  = 30,
    parameter int          BLINK_PERIOD = 8,
    parameter int          BLINK_COUNT  = 6,
    parameter logic [23:0] KEY_COLOR    = 24'hFF0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        menu_en,
    input  logic        frame_start,
    input  logic        key_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [18:0] read_address,
    input  logic [23:0] data_in_0,
    input  logic [23:0] data_in_1,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        menu_done
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ANIMATE = 2'd1;
    localparam logic [1:0] ST_BLINK   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + 2 * IMG_W);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + 2 * IMG_H);

    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_PERIOD) ? HOLD_FRAMES : BLINK_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(BLINK_COUNT + 1);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_PERIOD - 1);

    logic [1:0]    state;
    logic          cur_frame;
    logic          visible;
    logic [CW-1:0] hold_cnt;
    logic [BW-1:0] blink_left;

    logic          in_region;
    logic [9:0]    rel_x;
    logic [9:0]    rel_y;
    logic [18:0]   addr_next;
    logic          in_region_q;
    logic          in_region_d;
    logic          sel_d;
    logic [23:0]   data_sel;
    logic          show;
    logic          valid_next;

    assign in_region = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    assign rel_x     = DrawX - X_LO;
    assign rel_y     = DrawY - Y_LO;
    // Each RAM pixel covers a 2x2 block of screen pixels.
    assign addr_next = in_region ? (19'(rel_y >> 1) * 19'(IMG_W) + 19'(rel_x >> 1)) : '0;

    assign data_sel   = sel_d ? data_in_1 : data_in_0;
    assign show       = (state == ST_ANIMATE) || ((state == ST_BLINK) && visible);
    assign valid_next = in_region_d && (data_sel != KEY_COLOR) && show && menu_en;
    assign menu_done  = (state == ST_DONE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            read_address <= '0;
            in_region_q  <= 1'b0;
            in_region_d  <= 1'b0;
            sel_d        <= 1'b0;
            pixel_rgb    <= '0;
            pixel_valid  <= 1'b0;
        end else begin
            read_address <= addr_next;
            in_region_q  <= in_region;
            in_region_d  <= in_region_q;
            sel_d        <= cur_frame;
            pixel_valid  <= valid_next;
            pixel_rgb    <= valid_next ? data_sel : '0;
        end
    end

    // cur_frame only moves on frame_start, so a visible frame never tears mid-scan.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            cur_frame  <= 1'b0;
            visible    <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            blink_left <= '0;
        end else if (!menu_en) begin
            state      <= ST_IDLE;
            cur_frame  <= 1'b0;
            visible    <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            blink_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_ANIMATE;
                    hold_cnt <= HOLD_LOAD;
                end
                ST_ANIMATE: begin
                    if (key_start) begin
                        state      <= ST_BLINK;
                        hold_cnt   <= BLINK_LOAD;
                        blink_left <= BW'(BLINK_COUNT);
                        visible    <= 1'b1;
                    end else if (frame_start) begin
                        if (hold_cnt == '0) begin
                            hold_cnt  <= HOLD_LOAD;
                            cur_frame <= ~cur_frame;
                        end else begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end
                    end
                end
                ST_BLINK: begin
                    if (frame_start) begin
                        if (hold_cnt == '0) begin
                            hold_cnt   <= BLINK_LOAD;
                            visible    <= ~visible;
                            blink_left <= blink_left - BW'(1);
                            if (blink_left == BW'(1)) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_anim_sequencer.sv
// Bench for menu_anim_sequencer: directed steps plus a randomized phase, checked every
// cycle against a frame-count based reference model and a simple registered-read RAM.
module tb_menu_anim_sequencer;

    localparam int          IMG_W        = 120;
    localparam int          IMG_H        = 100;
    localparam int          X0           = 200;
    localparam int          Y0           = 140;
    localparam int          HOLD_FRAMES  = 30;
    localparam int          BLINK_PERIOD = 8;
    localparam int          BLINK_COUNT  = 6;
    localparam logic [23:0] KEY_COLOR    = 24'hFF0000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        menu_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        key_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [23:0] data_in_0 = '0;
    logic [23:0] data_in_1 = '0;
    logic [18:0] read_address;
    logic [23:0] pixel_rgb;
    logic        pixel_valid;
    logic        menu_done;

    menu_anim_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .menu_en      (menu_en),
        .frame_start  (frame_start),
        .key_start    (key_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .read_address (read_address),
        .data_in_0    (data_in_0),
        .data_in_1    (data_in_1),
        .pixel_rgb    (pixel_rgb),
        .pixel_valid  (pixel_valid),
        .menu_done    (menu_done)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 animate, 2 blink, 3 done; frames derived from counts.
    int          m_mode = 0;
    int          anim_fs = 0;
    int          blink_fs = 0;
    bit          s1_r = 0;
    int          s1_a = 0;
    bit          s2_r = 0;
    int          s2_a = 0;
    bit          s2_f = 0;
    int          e_addr = 0;
    logic [23:0] e_rgb = '0;
    bit          e_valid = 0;
    bit          e_done = 0;

    function automatic logic [23:0] ram_val(input bit k, input int a);
        logic [31:0] av;
        av = a;
        if (a % 5 == 3) return KEY_COLOR;
        if (!k && a == 0) return 24'h9ff5ff;
        return {(k ? 8'hA0 : 8'h50), av[15:0]};
    endfunction

    function automatic bit in_reg(input int x, input int y);
        return (x >= X0) && (x < X0 + 2 * IMG_W) && (y >= Y0) && (y < Y0 + 2 * IMG_H);
    endfunction

    function automatic int addr_of(input int x, input int y);
        if (!in_reg(x, y)) return 0;
        return ((y - Y0) / 2) * IMG_W + (x - X0) / 2;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step;
        bit          cur_f;
        bit          vis;
        bit          show;
        logic [23:0] d;
        cur_f = ((anim_fs / HOLD_FRAMES) % 2) == 1;
        vis   = ((blink_fs / BLINK_PERIOD) % 2) == 0;
        show  = (m_mode == 1) || (m_mode == 2 && vis);
        d     = ram_val(s2_f, s2_a);
        if (!Reset_n) begin
            m_mode = 0; anim_fs = 0; blink_fs = 0;
            s1_r = 0; s1_a = 0; s2_r = 0; s2_a = 0; s2_f = 0;
            e_addr = 0; e_rgb = '0; e_valid = 0;
        end else begin
            e_valid = s2_r && (d != KEY_COLOR) && show && menu_en;
            e_rgb   = e_valid ? d : 24'h0;
            s2_r = s1_r; s2_a = s1_a; s2_f = cur_f;
            s1_r = in_reg(int'(DrawX), int'(DrawY));
            s1_a = addr_of(int'(DrawX), int'(DrawY));
            e_addr = s1_a;
            if (!menu_en) begin
                m_mode = 0; anim_fs = 0; blink_fs = 0;
            end else begin
                case (m_mode)
                    0: m_mode = 1;
                    1: begin
                        if (key_start) begin
                            m_mode = 2; blink_fs = 0;
                        end else if (frame_start) begin
                            anim_fs++;
                        end
                    end
                    2: begin
                        if (frame_start) begin
                            blink_fs++;
                            if (blink_fs == BLINK_PERIOD * BLINK_COUNT) m_mode = 3;
                        end
                    end
                    default: ;
                endcase
            end
        end
        e_done = (m_mode == 3);
    endtask

    task automatic tick;
        logic [18:0] a_pre;
        a_pre = read_address;
        model_step();
        @(posedge Clk);
        #1;
        data_in_0 = ram_val(1'b0, int'(a_pre));
        data_in_1 = ram_val(1'b1, int'(a_pre));
        chk("read_address", 24'(read_address), 24'(e_addr));
        chk("pixel_rgb", pixel_rgb, e_rgb);
        chk("pixel_valid", 24'(pixel_valid), 24'(e_valid));
        chk("menu_done", 24'(menu_done), 24'(e_done));
    endtask

    task automatic settle;
        repeat (3) tick();
    endtask

    task automatic pulse_fs(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic set_pos(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with menu enabled
        Reset_n = 1'b0; menu_en = 1'b1; set_pos(0, 0);
        tick(); tick();
        chk("rst_addr", 24'(read_address), 24'h0);
        chk("rst_rgb", pixel_rgb, 24'h0);
        chk("rst_valid", 24'(pixel_valid), 24'h0);
        chk("rst_done", 24'(menu_done), 24'h0);
        Reset_n = 1'b1;
        tick();

        // Address mapping and latency
        set_pos(200, 140); tick();
        chk("addr_origin", 24'(read_address), 24'd0);
        set_pos(439, 339); tick();
        chk("addr_corner", 24'(read_address), 24'd11999);
        chk("lat_early_valid", 24'(pixel_valid), 24'h0);
        set_pos(440, 339); tick();
        chk("addr_edge_out", 24'(read_address), 24'd0);
        chk("lat3_rgb", pixel_rgb, 24'h9ff5ff);
        chk("lat3_valid", 24'(pixel_valid), 24'h1);
        set_pos(206, 140); tick();
        tick();
        chk("edge_out_valid", 24'(pixel_valid), 24'h0);
        tick();
        chk("key_valid", 24'(pixel_valid), 24'h0);
        chk("key_rgb", pixel_rgb, 24'h0);

        // Animation: switch after 30 frame_starts, not after 29
        set_pos(200, 140);
        pulse_fs(29); settle();
        chk("anim_29", pixel_rgb, 24'h9ff5ff);
        pulse_fs(1); settle();
        chk("anim_30", pixel_rgb, 24'hA00000);
        pulse_fs(30); settle();
        chk("anim_60", pixel_rgb, 24'h9ff5ff);

        // Blink: key coincident with frame_start must not advance the frame
        pulse_fs(29);
        key_start = 1'b1; frame_start = 1'b1; tick();
        key_start = 1'b0; frame_start = 1'b0; tick();
        settle();
        chk("blink_no_advance", pixel_rgb, 24'h9ff5ff);
        pulse_fs(7); settle();
        chk("blink_vis_7", 24'(pixel_valid), 24'h1);
        pulse_fs(1); settle();
        chk("blink_hidden_8", 24'(pixel_valid), 24'h0);
        pulse_fs(8); settle();
        chk("blink_vis_16", 24'(pixel_valid), 24'h1);
        pulse_fs(31);
        chk("done_47", 24'(menu_done), 24'h0);
        pulse_fs(1);
        chk("done_48", 24'(menu_done), 24'h1);
        settle();
        chk("done_no_pixel", 24'(pixel_valid), 24'h0);
        key_start = 1'b1; tick(); key_start = 1'b0; tick();
        chk("key_in_done", 24'(menu_done), 24'h1);
        menu_en = 1'b0; tick();
        chk("done_exit", 24'(menu_done), 24'h0);
        menu_en = 1'b1;

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            DrawX       = 10'($urandom_range(450, 190));
            DrawY       = 10'($urandom_range(350, 130));
            frame_start = ($urandom_range(2, 0) == 0);
            key_start   = ($urandom_range(120, 0) == 0);
            menu_en     = ($urandom_range(250, 0) != 0);
            tick();
        end
        frame_start = 1'b0; key_start = 1'b0;

        // menu_en drop mid-blink, then re-entry restarts on frame 0
        menu_en = 1'b0; tick();
        menu_en = 1'b1; tick();
        set_pos(200, 140);
        pulse_fs(30);
        key_start = 1'b1; tick(); key_start = 1'b0;
        pulse_fs(20);
        menu_en = 1'b0; tick();
        chk("drop_done", 24'(menu_done), 24'h0);
        chk("drop_valid", 24'(pixel_valid), 24'h0);
        menu_en = 1'b1; settle();
        chk("reenter_frame0", pixel_rgb, 24'h9ff5ff);

        // Reset mid-blink
        key_start = 1'b1; tick(); key_start = 1'b0;
        pulse_fs(16);
        set_pos(439, 339);
        Reset_n = 1'b0; tick();
        chk("rst_mid_addr", 24'(read_address), 24'h0);
        chk("rst_mid_rgb", pixel_rgb, 24'h0);
        chk("rst_mid_valid", 24'(pixel_valid), 24'h0);
        chk("rst_mid_done", 24'(menu_done), 24'h0);
        tick();
        Reset_n = 1'b1; tick(); settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/menu_anim_sequencer.md
Name: menu_anim_sequencer

Overview:
- Sequences the start-menu sprite frame RAMs.
- Maps the VGA scan position (DrawX/DrawY) to a frame-RAM read address and alternates between two menu frame RAMs every HOLD_FRAMES video frames to animate the menu.
- On a start key press, blinks the menu, then reports completion to the top-level game FSM.
- Sits between the VGA controller, the two menu frame RAMs (one-cycle registered read, palette-expanded 24-bit output) and the colour mapper.

Parameters:
- IMG_W, 120, sprite width in RAM pixels.
- IMG_H, 100, sprite height in RAM pixels (IMG_W*IMG_H = 12000 RAM entries).
- X0, 200, screen X of the sprite's left edge.
- Y0, 140, screen Y of the sprite's top edge.
- HOLD_FRAMES, 30, video frames each animation frame is shown.
- BLINK_PERIOD, 8, video frames per blink half-period.
- BLINK_COUNT, 6, visibility toggles before done.
- KEY_COLOR, 24'hFF0000, transparent colour.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  synchronous active-low reset
- menu_en  in  1  menu screen active (level)
- frame_start  in  1  one-cycle pulse at start of vertical blank
- key_start  in  1  one-cycle pulse, start key pressed
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- read_address  out  19  address to both menu frame RAMs
- data_in_0  in  24  frame RAM 0 output
- data_in_1  in  24  frame RAM 1 output
- pixel_rgb  out  24  menu pixel colour
- pixel_valid  out  1  menu pixel opaque and visible
- menu_done  out  1  level; blink sequence finished

Behaviour:
- Scaled region: sprite displayed at 2x scale. in_region = X0 <= DrawX < X0+2*IMG_W and Y0 <= DrawY < Y0+2*IMG_H.
- Address: read_address = ((DrawY-Y0)>>1)*IMG_W + ((DrawX-X0)>>1) when in_region, else 0. Unsigned 19-bit arithmetic.
- Pipeline:
  - Cycle 1: read_address and in_region registered.
  - Cycle 2: RAM data returns; sel and in_region delayed one more stage.
  - Cycle 3: pixel_rgb and pixel_valid registered.
  - Total latency from DrawX/DrawY to pixel_rgb/pixel_valid is 3 cycles.
- Data mux: pixel_rgb = data_in_[sel_d] from the cycle-2 sel.
- pixel_valid (all conditions required): in_region_d; data != KEY_COLOR; state is ANIMATE, or BLINK with visible=1; menu_en.
- When pixel_valid=0, pixel_rgb = 0.
- States:
  - IDLE: cur_frame=0, counters=0, visible=1. Go to ANIMATE when menu_en=1.
  - ANIMATE: on each frame_start, hold_cnt increments. At hold_cnt==HOLD_FRAMES-1 it clears to 0 and cur_frame toggles (0->1->0 wrap). key_start -> BLINK, clears hold_cnt and blink_cnt, sets visible=1.
  - BLINK: cur_frame frozen. On each frame_start, hold_cnt increments. At BLINK_PERIOD-1 it clears, visible toggles and blink_cnt increments. When blink_cnt reaches BLINK_COUNT, go to DONE.
  - DONE: menu_done=1, pixel_valid=0. Hold until menu_en=0.
- menu_en=0 in any state -> IDLE on the next edge. The pipeline keeps draining, but pixel_valid is gated to 0 from the next cycle.
- sel (the frame index driving the mux) changes only on a frame_start edge, so there is no intra-frame tearing.
- Priorities:
  - menu_en=0 > key_start > frame_start.
  - key_start and frame_start in the same cycle in ANIMATE: enter BLINK; cur_frame does not advance.
  - key_start outside ANIMATE is ignored.
- Reset (Reset_n=0 at a Clk edge, including mid-blink): state=IDLE, all pipeline registers 0, read_address=0, pixel_rgb=0, pixel_valid=0, menu_done=0, cur_frame=0.

Test Plan:
- Reset_n=0 for 2 cycles with menu_en=1 -> all outputs 0; state IDLE. Release -> ANIMATE after 1 cycle.
- Address mapping: DrawX=200, DrawY=140 -> read_address=0 one cycle later. DrawX=439, DrawY=339 -> 11999. DrawX=440 -> 0 and pixel_valid=0 three cycles later.
- Transparency and latency: data_in_0=24'h9ff5ff in-region -> pixel_rgb=24'h9ff5ff, pixel_valid=1 exactly 3 cycles after DrawX/DrawY. data_in_0=24'hFF0000 -> pixel_valid=0, pixel_rgb=0.
- Animation: 30 frame_start pulses -> mux switches to data_in_1. 30 more -> back to data_in_0. A frame with 29 pulses -> no switch.
- Blink: key_start coincident with frame_start -> no frame advance. visible toggles every 8 frame_starts. After 48 frame_starts, menu_done=1 and pixel_valid stays 0.
- menu_en=0 mid-BLINK -> IDLE next cycle, menu_done=0. menu_en=1 again -> ANIMATE with cur_frame=0.
